bcd_scan_ctrl: RTL

Time-multiplexing controller that shares one BCD-to-decimal decode path across `NUM_DIGITS` BCD digits. It accepts a packed digit word over a valid/ready handshake, double-buffers it, and scans the digits round-robin. Each scan step drives a one-hot digit select alongside the 10-line one-hot decoded value. It sits between the numeric datapath (counters, BCD converters) and the multiplexed decimal indicator outputs.

---
 rtl/bcd_scan_ctrl_pkg.sv | 24 ++
 rtl/bcd_scan_ctrl_dec.sv | 13 +
 rtl/bcd_scan_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/bcd_scan_ctrl_pkg.sv
// rtl/bcd_scan_ctrl_pkg.sv - shared types, widths and BCD decode helper for the digit scanner
package bcd_scan_pkg;

   localparam int BCD_W = 4;
   localparam int DEC_W = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } scan_state_t;

   // Codes 10..15 decode to all-zero so an invalid digit lights nothing.
   function automatic logic [DEC_W-1:0] bcd_onehot(input logic [BCD_W-1:0] code);
      logic [DEC_W-1:0] one;
      one = {{(DEC_W-1){1'b0}}, 1'b1};
      if (code < 4'd10) begin
         bcd_onehot = one << code;
      end else begin
         bcd_onehot = '0;
      end
   endfunction

endpackage

// File: rtl/bcd_scan_ctrl_dec.sv
// rtl/bcd_scan_ctrl_dec.sv - combinational 4-to-10 one-hot BCD decoder with invalid-code flag
module bcd_onehot_dec
   import bcd_scan_pkg::*;
(
   input  logic [BCD_W-1:0] code,
   output logic [DEC_W-1:0] dec,
   output logic             invalid
);

   assign dec     = bcd_onehot(code);
   assign invalid = (code > 4'd9);

endmodule

// File: rtl/bcd_scan_ctrl.sv
// rtl/bcd_scan_ctrl.sv - double-buffered round-robin BCD digit scanner with blanking gaps
// Define BCD_SCAN_LZB_EN to enable leading-zero blanking.
module bcd_scan_ctrl
   import bcd_scan_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 1000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        load_valid,
   output logic                        load_ready,
   input  logic [BCD_W*NUM_DIGITS-1:0] load_data,
   output logic [NUM_DIGITS-1:0]       dig_sel,
   output logic [DEC_W-1:0]            dec_out,
   output logic                        invalid,
   output logic                        frame_done
);

   localparam int WORD_W  = BCD_W * NUM_DIGITS;
   localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int IDX_W   = $clog2(NUM_DIGITS);

   localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   scan_state_t        state, state_n;
   logic [WORD_W-1:0]  active, active_n;
   logic [WORD_W-1:0]  pending, pending_n;
   logic               pend_vld, pend_vld_n;
   logic [IDX_W-1:0]   idx, idx_n;
   logic [CNT_W-1:0]   cnt, cnt_n;

   logic [NUM_DIGITS-1:0] sel_n;
   logic [DEC_W-1:0]      dec_n;
   logic                  inv_n;
   logic                  fd_n;
   logic                  lead_blank;
   logic [BCD_W-1:0]      digit_mux;
   logic [DEC_W-1:0]      digit_dec;
   logic                  digit_inv;
   logic                  transfer;

   assign load_ready = ~pend_vld & ~rst;
   assign transfer   = load_valid & load_ready;

   always_comb begin
      state_n    = state;
      active_n   = active;
      pending_n  = pending;
      pend_vld_n = pend_vld;
      idx_n      = idx;
      cnt_n      = cnt;

      // transfer implies ~pend_vld, so this never collides with the frame commit below
      if (transfer && (state != IDLE)) begin
         pending_n  = load_data;
         pend_vld_n = 1'b1;
      end

      unique case (state)
         IDLE: begin
            if (transfer) begin
               active_n = load_data;
               state_n  = BLANK;
               idx_n    = '0;
               cnt_n    = '0;
            end
         end
         BLANK: begin
            if (cnt == BLANK_LAST) begin
               state_n = DRIVE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DRIVE: begin
            if (cnt == SCAN_LAST) begin
               state_n = BLANK;
               cnt_n   = '0;
               if (idx == IDX_LAST) begin
                  idx_n = '0;
                  if (pend_vld) begin
                     active_n   = pending;
                     pend_vld_n = 1'b0;
                  end
               end else begin
                  idx_n = idx + 1'b1;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Outputs are decoded from next-state values and registered, so they line up with state.
   assign digit_mux = active_n[idx_n*BCD_W +: BCD_W];

   bcd_onehot_dec u_dec (
      .code    (digit_mux),
      .dec     (digit_dec),
      .invalid (digit_inv)
   );

   always_comb begin
      sel_n      = '0;
      dec_n      = '0;
      inv_n      = 1'b0;
      fd_n       = 1'b0;
      lead_blank = 1'b0;
`ifdef BCD_SCAN_LZB_EN
      lead_blank = (idx_n != '0) && ((active_n >> (idx_n*BCD_W)) == '0);
`endif
      if (state_n == DRIVE) begin
         inv_n = digit_inv;
         fd_n  = (idx_n == IDX_LAST) && (cnt_n == SCAN_LAST);
         if (!lead_blank) begin
            sel_n = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_n;
            dec_n = digit_dec;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         active     <= '0;
         pending    <= '0;
         pend_vld   <= 1'b0;
         idx        <= '0;
         cnt        <= '0;
         dig_sel    <= '0;
         dec_out    <= '0;
         invalid    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         active     <= active_n;
         pending    <= pending_n;
         pend_vld   <= pend_vld_n;
         idx        <= idx_n;
         cnt        <= cnt_n;
         dig_sel    <= sel_n;
         dec_out    <= dec_n;
         invalid    <= inv_n;
         frame_done <= fd_n;
      end
   end

endmodule
